elevator_request_scheduler: RTL and testbench

Request-latching and motion-sequencing controller for the four-floor elevator car. Latches hall and car calls, chooses travel direction with directional (collective) scheduling, and issues registered move and door commands to the car position datapath. It sits between the button inputs and the car datapath, replacing per-state next-state logic with one explicit FSM plus a door dwell timer.

---
 rtl/elevator_request_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// Four-floor elevator request latch and collective-scheduling FSM with a door dwell timer.
// Defining ELEVATOR_IDLE_HOME_EN adds an idle timeout that returns the empty car to F1.
module elevator_request_scheduler #(
    parameter int DWELL_CYCLES = 3
`ifdef ELEVATOR_IDLE_HOME_EN
    ,
    parameter int HOME_TIMEOUT = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] button_up,
    input  logic [2:0] button_down,
    input  logic [3:0] button_in,
    input  logic [2:0] position,
    output logic [1:0] move_cmd,
    output logic       open,
    output logic [1:0] direction,
    output logic [2:0] pend_up,
    output logic [2:0] pend_down,
    output logic [3:0] pend_in,
    output logic       busy,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_DWELL = 2'd3} state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic [1:0]    r_move, w_move_nxt;
    logic          r_open, w_open_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_pend_up, r_pend_dn;
    logic [3:0]    r_pend_in;
    logic [3:0]    w_up4, w_dn4, w_req4, w_oh, w_above_m, w_below_m;
    logic [1:0]    w_f;
    logic          w_any, w_above, w_below, w_here, w_stop;
    logic          w_clr_en, w_clr_up, w_clr_dn, w_homing, w_home_go;

    // Per-floor views of the hall calls; absent buttons (up at F4, down at F1) are zero.
    assign w_up4  = {1'b0, r_pend_up};
    assign w_dn4  = {r_pend_dn, 1'b0};
    assign w_req4 = w_up4 | w_dn4 | r_pend_in;
    assign w_any  = |w_req4;

    // Between floors, decisions are made for the floor the car is about to enter.
    assign w_f       = (position[0] && r_state == S_UP) ? position[2:1] + 2'd1 : position[2:1];
    assign w_oh      = 4'b0001 << w_f;
    assign w_above_m = 4'b1110 << w_f;
    assign w_below_m = w_oh - 4'd1;
    assign w_above   = |(w_req4 & w_above_m);
    assign w_below   = |(w_req4 & w_below_m);
    assign w_here    = |(w_req4 & w_oh);

    assign w_clr_en = w_stop || (r_state == S_DWELL);
    assign w_clr_up = w_clr_en && (r_dir != DIR_DN || !w_below);
    assign w_clr_dn = w_clr_en && (r_dir != DIR_UP || !w_above);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_move_nxt  = r_move;
        w_open_nxt  = r_open;
        w_cnt_nxt   = r_cnt;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_stop = 1'b1;
                end else if (w_above) begin
                    w_state_nxt = S_UP;
                    w_dir_nxt   = DIR_UP;
                    w_move_nxt  = DIR_UP;
                end else if (w_below || w_home_go) begin
                    w_state_nxt = S_DOWN;
                    w_dir_nxt   = DIR_DN;
                    w_move_nxt  = DIR_DN;
                end
            end
            S_UP: begin
                // F4 has nothing above it, so !w_above also forces the top-floor stop.
                if (position[0] && (r_pend_in[w_f] || w_up4[w_f] || !w_above)) begin
                    w_stop = 1'b1;
                end
            end
            S_DOWN: begin
                if (position[0]) begin
                    if (w_homing && !w_any) begin
                        if (w_f == 2'd0) begin
                            w_state_nxt = S_IDLE;
                            w_dir_nxt   = DIR_NONE;
                            w_move_nxt  = DIR_NONE;
                        end
                    end else if (r_pend_in[w_f] || w_dn4[w_f] || !w_below) begin
                        w_stop = 1'b1;
                    end
                end
            end
            default: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_open_nxt = 1'b0;
                    if (w_above && (r_dir != DIR_DN || !w_below)) begin
                        w_state_nxt = S_UP;
                        w_dir_nxt   = DIR_UP;
                        w_move_nxt  = DIR_UP;
                    end else if (w_below) begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                        w_move_nxt  = DIR_DN;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_dir_nxt   = DIR_NONE;
                    end
                end
            end
        endcase
        if (w_stop) begin
            w_state_nxt = S_DWELL;
            w_move_nxt  = DIR_NONE;
            w_open_nxt  = 1'b1;
            w_cnt_nxt   = DWELL_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dir     <= DIR_NONE;
            r_move    <= DIR_NONE;
            r_open    <= 1'b0;
            r_cnt     <= '0;
            r_pend_up <= '0;
            r_pend_dn <= '0;
            r_pend_in <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_move    <= w_move_nxt;
            r_open    <= w_open_nxt;
            r_cnt     <= w_cnt_nxt;
            // Service clear wins over a press of the same bit on the same edge.
            r_pend_up <= (r_pend_up | button_up) & ~(w_clr_up ? w_oh[2:0] : 3'b000);
            r_pend_dn <= (r_pend_dn | button_down) & ~(w_clr_dn ? w_oh[3:1] : 3'b000);
            r_pend_in <= (r_pend_in | button_in) & ~(w_clr_en ? w_oh : 4'b0000);
        end
    end

`ifdef ELEVATOR_IDLE_HOME_EN
    localparam int HW = $clog2(HOME_TIMEOUT + 1);
    logic [HW-1:0] r_idle_cnt;
    logic          r_homing;

    assign w_homing  = r_homing;
    assign w_home_go = (r_state == S_IDLE) && !w_any && (position != 3'b000) &&
                       (r_idle_cnt == HW'(HOME_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt <= '0;
            r_homing   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && !w_any && !w_home_go) begin
                if (r_idle_cnt != HW'(HOME_TIMEOUT - 1)) r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
            if (w_home_go) begin
                r_homing <= 1'b1;
            end else if (r_state == S_DOWN && position[0] && (w_any || w_f == 2'd0)) begin
                r_homing <= 1'b0;
            end
        end
    end
`else
    assign w_homing  = 1'b0;
    assign w_home_go = 1'b0;
`endif

    assign move_cmd  = r_move;
    assign open      = r_open;
    assign direction = r_dir;
    assign pend_up   = r_pend_up;
    assign pend_down = r_pend_dn;
    assign pend_in   = r_pend_in;
    assign busy      = (r_state != S_IDLE) || w_any;
    assign o_state   = r_state;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a half-floor car position model.
// The homing checks switch on when ELEVATOR_IDLE_HOME_EN is defined.
module tb_elevator_request_scheduler;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DOWN  = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] button_up, button_down;
    logic [3:0] button_in;
    logic [2:0] position;
    logic [1:0] move_cmd, direction, o_state;
    logic       open, busy;
    logic [2:0] pend_up, pend_down;
    logic [3:0] pend_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    elevator_request_scheduler dut (
        .clk(clk), .reset(reset),
        .button_up(button_up), .button_down(button_down), .button_in(button_in),
        .position(position),
        .move_cmd(move_cmd), .open(open), .direction(direction),
        .pend_up(pend_up), .pend_down(pend_down), .pend_in(pend_in),
        .busy(busy), .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Car datapath: applies move_cmd on the next edge, reset together with the controller.
    always @(posedge clk) begin
        if (reset)                   position <= 3'd0;
        else if (move_cmd == 2'b01)  position <= position + 3'd1;
        else if (move_cmd == 2'b10)  position <= position - 3'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_open(output int cnt);
        cnt = 0;
        while (!open && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_open(output int cnt);
        cnt = 0;
        while (open && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_move(input logic [1:0] m, output int cnt);
        cnt = 0;
        while (move_cmd == m && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        logic seen;
        // Reset held two edges with every button pressed.
        reset = 1'b1; button_up = 3'b111; button_down = 3'b111; button_in = 4'b1111;
        tick(); tick();
        chk("rst_move", 8'(move_cmd), 8'h0);
        chk("rst_open", 8'(open), 8'h0);
        chk("rst_dir", 8'(direction), 8'h0);
        chk("rst_pend_up", 8'(pend_up), 8'h0);
        chk("rst_pend_dn", 8'(pend_down), 8'h0);
        chk("rst_pend_in", 8'(pend_in), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_state", 8'(o_state), 8'(ST_IDLE));
        reset = 1'b0; button_up = '0; button_down = '0; button_in = '0;

        // F1 -> F4 with a F2 down call: pass F2, stop F4, reverse to F2.
        button_in = 4'b1000; tick(); button_in = '0;
        chk("press_latch", 8'(pend_in), 8'h08);
        chk("idle_before_move", 8'(move_cmd), 8'h0);
        tick();
        chk("up_move", 8'(move_cmd), 8'h1);
        chk("up_dir", 8'(direction), 8'h1);
        button_down = 3'b001; tick(); button_down = '0;
        chk("hall_dn_latch", 8'(pend_down), 8'h1);
        wait_open(n);
        chk("stop_f4_pos", 8'(position), 8'h6);
        chk("f4_pend_dn_kept", 8'(pend_down), 8'h1);
        chk("f4_pend_in_clr", 8'(pend_in), 8'h0);
        count_open(n);
        chk("f4_dwell_len", 8'(n), 8'h3);
        chk("rev_dir", 8'(direction), 8'h2);
        chk("rev_move", 8'(move_cmd), 8'h2);
        chk("rev_state", 8'(o_state), 8'(ST_DOWN));
        wait_open(n);
        chk("stop_f2_pos", 8'(position), 8'h2);
        chk("f2_pend_dn_clr", 8'(pend_down), 8'h0);
        chk("f2_dir", 8'(direction), 8'h2);
        count_open(n);
        chk("f2_dwell_len", 8'(n), 8'h3);
        chk("f2_idle", 8'(o_state), 8'(ST_IDLE));
        chk("f2_dir_none", 8'(direction), 8'h0);

        // Calls at F2 during dwell are absorbed without extending the dwell.
        button_in = 4'b0010; tick(); button_in = '0; tick();
        chk("dw_open", 8'(open), 8'h1);
        chk("dw_state", 8'(o_state), 8'(ST_DWELL));
        button_up = 3'b010; button_in = 4'b0010; tick(); button_up = '0; button_in = '0;
        chk("dw_absorb_up", 8'(pend_up), 8'h0);
        chk("dw_absorb_in", 8'(pend_in), 8'h0);
        chk("dw_still_open", 8'(open), 8'h1);
        count_open(n);
        chk("dw_len", 8'(n + 1), 8'h3);
        chk("dw_idle", 8'(o_state), 8'(ST_IDLE));
        chk("dw_busy", 8'(busy), 8'h0);

        // Reset while between F2 and F3 moving up.
        button_in = 4'b1000; tick(); button_in = '0; tick(); tick();
        chk("mid_pos", 8'(position), 8'h3);
        chk("mid_move", 8'(move_cmd), 8'h1);
        reset = 1'b1; tick();
        chk("mid_rst_move", 8'(move_cmd), 8'h0);
        chk("mid_rst_state", 8'(o_state), 8'(ST_IDLE));
        chk("mid_rst_pend", 8'(pend_in), 8'h0);
        chk("mid_rst_dir", 8'(direction), 8'h0);
        reset = 1'b0;

        // F1 idle, car call F3: four cycles of move up, three of open door.
        button_in = 4'b0100; tick(); button_in = '0;
        chk("f3_latch", 8'(pend_in), 8'h04);
        tick();
        count_move(2'b01, n);
        chk("f3_move_len", 8'(n), 8'h4);
        chk("f3_pos", 8'(position), 8'h4);
        chk("f3_open", 8'(open), 8'h1);
        chk("f3_pend_clr", 8'(pend_in), 8'h0);
        count_open(n);
        chk("f3_dwell_len", 8'(n), 8'h3);
        chk("f3_idle", 8'(o_state), 8'(ST_IDLE));
        chk("f3_dir", 8'(direction), 8'h0);

`ifdef ELEVATOR_IDLE_HOME_EN
        count_move(2'b00, n);
        chk("home_idle_len", 8'(n), 8'h8);
        seen = 1'b0; n = 0;
        while (move_cmd != 2'b00 && n < 20) begin
            if (open || move_cmd != 2'b10) seen = 1'b1;
            n++;
            tick();
        end
        chk("home_move_len", 8'(n), 8'h4);
        chk("home_no_open", 8'(seen), 8'h0);
        chk("home_pos", 8'(position), 8'h0);
        chk("home_idle", 8'(o_state), 8'(ST_IDLE));
`else
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (move_cmd != 2'b00 || open) seen = 1'b1;
        end
        chk("hold_no_move", 8'(seen), 8'h0);
        chk("hold_pos", 8'(position), 8'h4);
        chk("hold_idle", 8'(o_state), 8'(ST_IDLE));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
